mspacman_dl_ctrl: RTL and testbench
===================================

Name: mspacman_dl_ctrl

Overview:
Sequences ROM download from the HPS ioctl bus into the pacman core's dn_* write port, and owns the core reset.
- Buffers ioctl writes in a small FIFO.
- Replays buffered writes to the core only on ENA_6 cycles.
- Range-checks addresses and counts bytes.
- Holds the core in reset during download and for a fixed stretch afterwards.
- Releases the core only when the image is complete and error-free.

Sits between hps_io and the pacman core in the emu top.

Parameters:
- ROM_SIZE, 49152: expected image size in bytes; valid addresses are 0..ROM_SIZE-1.
- ADDR_W, 16: width of dn_addr.
- FIFO_DEPTH, 4: write buffer entries; power of two.
- HOLD_CYCLES, 256: CLK cycles core_reset stays high after drain or user reset.

Ports:
- CLK, in, 1: system clock (clk_sys).
- RESET, in, 1: synchronous active-high reset.
- ce, in, 1: 6 MHz clock enable (ENA_6).
- ioctl_download, in, 1: download window active.
- ioctl_wr, in, 1: single-cycle write strobe.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: write data.
- user_reset, in, 1: menu/button reset request, level.
- dn_addr, out, ADDR_W: core ROM write address.
- dn_data, out, 8: core ROM write data.
- dn_wr, out, 1: core ROM write strobe, one CLK wide.
- core_reset, out, 1: reset to pacman core.
- busy, out, 1: high in every state except RUN (drives LED_USER).
- rom_ok, out, 1: last download complete and clean.
- err, out, 3: sticky {size_err, range_err, ovf_err}.

Behaviour:
- Reset values:
  - State IDLE.
  - dn_wr=0, dn_addr=0, dn_data=0.
  - core_reset=1, busy=1, rom_ok=0, err=0.
  - FIFO empty, byte counter 0, hold counter 0.
- States: IDLE, LOAD, DRAIN, HOLD, RUN, FAIL.
- IDLE: core_reset=1. Moves to LOAD when ioctl_download=1.
- LOAD entry (from any state, on the rising edge of ioctl_download):
  - Clears err, rom_ok, byte counter and FIFO.
  - core_reset=1 throughout LOAD.
- Write accept, in LOAD or DRAIN:
  - Applies when ioctl_wr=1.
  - ioctl_addr >= ROM_SIZE: write dropped, range_err set.
  - FIFO full with no pop in the same cycle: write dropped, ovf_err set.
  - Otherwise: push {addr[ADDR_W-1:0], data} and increment the byte counter (17 bits, saturating).
  - Simultaneous push and pop when full is legal; the entry count is unchanged.
- Pop: occurs in any cycle with ce=1 and FIFO non-empty. That same cycle:
  - dn_wr=1.
  - dn_addr/dn_data are registered from the FIFO head.
  - dn_wr is 0 in all other cycles.
  - dn_addr/dn_data hold their last value.
- Latency: a write accepted at cycle t appears on dn_* at the first ce cycle strictly after t (minimum t+1). FIFO order is preserved.
- LOAD -> DRAIN when ioctl_download falls.
- DRAIN -> HOLD when the FIFO is empty. At the same time:
  - size_err is set if byte counter != ROM_SIZE.
  - Hold counter loads HOLD_CYCLES-1.
- HOLD:
  - core_reset=1; counter decrements every CLK cycle.
  - At 0: go to RUN if err==0, otherwise FAIL.
  - rom_ok=1 on entering RUN.
- RUN: core_reset=0, busy=0. user_reset=1 -> HOLD with counter reloaded; rom_ok stays 1.
- FAIL:
  - core_reset=1, busy=1; user_reset is ignored.
  - Only a new download or RESET leaves FAIL.
- Download rising while in DRAIN or HOLD: abandons the current sequence and restarts LOAD, flushing the FIFO without popping.
- RESET mid-download: immediate return to reset values. Subsequent ioctl_wr is ignored until the next ioctl_download rising edge.
- ioctl_wr outside LOAD/DRAIN: ignored, no error.

Decomposition:
- Package mspacman_pkg holds:
  - State enum dl_state_t.
  - Error bit indices ERR_OVF=0, ERR_RANGE=1, ERR_SIZE=2.
  - Default localparams for ROM size and hold length, shared with the emu top.
- One sub-module, dl_fifo: synchronous FIFO with parameters DEPTH and WIDTH, and ports push, pop, din, dout, full, empty, flush.

Test Plan:
- Clean load of 49152 sequential bytes, one write every 8 CLK, ce every 4 CLK:
  - 49152 dn_wr pulses with matching addr/data in order.
  - core_reset stays 1 until 256 cycles after the FIFO empties, then 0.
  - rom_ok=1, err=0.
- Short image of 49151 bytes: err=3'b100, state FAIL, core_reset stays 1. A user_reset pulse has no effect.
- Write at address 0xC000: the write is dropped, no dn_wr for it, err[1]=1, ends in FAIL.
- Burst of 6 back-to-back ioctl_wr with ce held low: first 4 accepted, last 2 dropped, err[0]=1. Raising ce drains exactly 4 pulses.
- In RUN, user_reset for 1 cycle: core_reset=1 for exactly 256 CLK, then 0; rom_ok remains 1.
- Download restarted while in HOLD, or RESET asserted mid-LOAD:
  - FIFO flushed with no stale dn_wr.
  - err cleared.
  - Counter restarts from 0.

Source files
------------

// File: rtl/mspacman_pkg.sv
// Shared types and defaults for the Ms. Pac-Man ROM download controller.
package mspacman_pkg;

  // Controller sequence: download, drain, hold reset, then run (or stop in FAIL).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAIL  = 3'd5
  } dl_state_t;

  // Bit positions inside the sticky error vector.
  localparam int ERR_OVF   = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_SIZE  = 2;

  // Defaults shared with the emu top.
  localparam int ROM_SIZE_DEFAULT    = 49152;
  localparam int HOLD_CYCLES_DEFAULT = 256;
  localparam int ADDR_W_DEFAULT      = 16;
  localparam int FIFO_DEPTH_DEFAULT  = 4;

  // Byte counter is wide enough to count one byte past a 64 KiB image.
  localparam int BYTE_CNT_W = 17;

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO buffering ioctl writes until the next ce slot.
// DEPTH must be a power of two and at least 2. The head word is read
// combinationally so a pop can present it in the same cycle.
module dl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = ((wr_ptr_q - rd_ptr_q) == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointer update; flush wins over any simultaneous push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !srst) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/mspacman_dl_ctrl.sv
// ROM download sequencer: buffers hps_io ioctl writes, replays them to the
// core's dn_* port on ce slots, validates the image and owns core reset.
module mspacman_dl_ctrl
  import mspacman_pkg::*;
#(
  parameter int ROM_SIZE    = ROM_SIZE_DEFAULT,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ce,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              user_reset,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              core_reset,
  output logic              busy,
  output logic              rom_ok,
  output logic [2:0]        err
);

  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int ENTRY_W = ADDR_W + 8;

  localparam logic [HOLD_W-1:0]     HOLD_LOAD    = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BYTE_CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [BYTE_CNT_W-1:0] ROM_SIZE_CNT = BYTE_CNT_W'(ROM_SIZE);
  localparam logic [24:0]           ROM_LIMIT    = 25'(ROM_SIZE);

  dl_state_t              state_q, state_d;
  logic                   dl_prev_q, dl_prev_d;
  logic [2:0]             err_q, err_d;
  logic                   rom_ok_q, rom_ok_d;
  logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0]      last_addr_q, last_addr_d;
  logic [7:0]             last_data_q, last_data_d;

  logic                   dl_rise;
  logic                   accepting;
  logic                   wr_in_range;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENTRY_W-1:0]     fifo_dout;

  assign dl_rise     = ioctl_download & ~dl_prev_q;
  assign accepting   = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) & ~dl_rise;
  assign wr_in_range = (ioctl_addr < ROM_LIMIT);
  // A restart flushes the buffer, so nothing is replayed in that cycle.
  assign fifo_pop    = ce & ~fifo_empty & ~dl_rise & ~RESET;
  assign fifo_push   = accepting & ioctl_wr & wr_in_range & (~fifo_full | fifo_pop);

  dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .srst  (RESET),
    .flush (dl_rise),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, write accounting, hold timer and replay data selection.
  always_comb begin
    state_d     = state_q;
    dl_prev_d   = ioctl_download;
    err_d       = err_q;
    rom_ok_d    = rom_ok_q;
    byte_cnt_d  = byte_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;

    if (fifo_pop) begin
      last_addr_d = fifo_dout[ENTRY_W-1:8];
      last_data_d = fifo_dout[7:0];
    end

    if (accepting && ioctl_wr) begin
      if (!wr_in_range) begin
        err_d[ERR_RANGE] = 1'b1;
      end else if (fifo_full && !fifo_pop) begin
        err_d[ERR_OVF] = 1'b1;
      end else if (byte_cnt_q != CNT_MAX) begin
        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: ;
      ST_LOAD: begin
        if (!ioctl_download) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait until every buffered byte has reached the core.
        if (fifo_empty && !fifo_push) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
          if (byte_cnt_q != ROM_SIZE_CNT) err_d[ERR_SIZE] = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          if (err_q == 3'b000) begin
            state_d  = ST_RUN;
            rom_ok_d = 1'b1;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (user_reset) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_FAIL: ;
      default: state_d = ST_IDLE;
    endcase

    // A new download abandons whatever sequence is in progress.
    if (dl_rise) begin
      state_d    = ST_LOAD;
      err_d      = 3'b000;
      rom_ok_d   = 1'b0;
      byte_cnt_d = '0;
    end
  end

  // State registers. dl_prev resets high so a download already in progress
  // across RESET is not mistaken for a new one; only a fresh edge restarts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      dl_prev_q   <= 1'b1;
      err_q       <= 3'b000;
      rom_ok_q    <= 1'b0;
      byte_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      dl_prev_q   <= dl_prev_d;
      err_q       <= err_d;
      rom_ok_q    <= rom_ok_d;
      byte_cnt_q  <= byte_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // dn_* shows the FIFO head during a pop and holds the last replayed word otherwise.
  assign dn_wr      = fifo_pop;
  assign dn_addr    = last_addr_d;
  assign dn_data    = last_data_d;
  assign core_reset = (state_q != ST_RUN);
  assign busy       = (state_q != ST_RUN);
  assign rom_ok     = rom_ok_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mspacman_dl_ctrl.sv
// Directed bench for mspacman_dl_ctrl with a reduced image size.
module tb_mspacman_dl_ctrl;

  localparam int ROM_SIZE = 256;
  localparam int HOLD     = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        user_reset = 1'b0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        busy;
  logic        rom_ok;
  logic [2:0]  err;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pulses = 0;
  bit          ce_en = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    bit          ok;
    logic [2:0]  exp_err;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mspacman_dl_ctrl #(
    .ROM_SIZE    (ROM_SIZE),
    .ADDR_W      (16),
    .FIFO_DEPTH  (4),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .ce             (ce),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .user_reset     (user_reset),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .core_reset     (core_reset),
    .busy           (busy),
    .rom_ok         (rom_ok),
    .err            (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] dat(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Scoreboard: every dn_wr pulse must match the oldest accepted write.
  always @(negedge clk) begin
    if (dn_wr === 1'b1) begin
      pulses++;
      $display("dn_wr addr=%04h data=%02h", dn_addr, dn_data);
      check("dn_wr_on_ce", 32'(ce), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dn_wr actual addr=%0h data=%0h required no pulse", dn_addr, dn_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("dn_payload", 32'({dn_addr, dn_data}), 32'(mon_e));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    ioctl_wr = 1'b0;
    ce = ce_en && (cyc % 4 == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input bit expect_ok);
    next_cycle();
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (expect_ok) exp_q.push_back({a[15:0], d});
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      write_byte(25'(i), dat(i), 1'b1);
      idle(7);
    end
  endtask

  task automatic start_dl();
    next_cycle();
    ioctl_download = 1'b1;
    next_cycle();
  endtask

  task automatic end_dl();
    next_cycle();
    ioctl_download = 1'b0;
  endtask

  task automatic wait_q_empty();
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) next_cycle();
    @(negedge clk);
    check("fifo_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Counts cycles with core_reset high, starting with the current one.
  task automatic count_reset_high(output int n);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (core_reset === 1'b0) break;
      n++;
      next_cycle();
    end
  endtask

  task automatic clean_body();
    int n;
    ce_en = 1'b1;
    feed(ROM_SIZE);
    wait_q_empty();
    end_dl();
    count_reset_high(n);
    check("release_delay", 32'(n), 32'(HOLD + 2));
    check("run_busy", 32'(busy), 32'd0);
    check("run_rom_ok", 32'(rom_ok), 32'd1);
    check("run_err", 32'(err), 32'd0);
  endtask

  initial begin
    int n;
    int p0;
    vecs[0] = '{25'h0000000, 8'hA5, 1'b1, 3'b000};
    vecs[1] = '{25'h0000100, 8'h11, 1'b0, 3'b010};
    vecs[2] = '{25'h00000FF, 8'h3C, 1'b1, 3'b010};
    vecs[3] = '{25'h000C000, 8'h77, 1'b0, 3'b010};
    vecs[4] = '{25'h0000001, 8'h81, 1'b1, 3'b010};
    vecs[5] = '{25'h1FFFFFF, 8'h22, 1'b0, 3'b010};
    vecs[6] = '{25'h000007F, 8'h0E, 1'b1, 3'b010};
    vecs[7] = '{25'h0010080, 8'h33, 1'b0, 3'b010};

    // Reset values.
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    check("rst_dn_wr", 32'(dn_wr), 32'd0);
    check("rst_dn_addr", 32'(dn_addr), 32'd0);
    check("rst_dn_data", 32'(dn_data), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rom_ok", 32'(rom_ok), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    next_cycle();
    rst = 1'b0;
    idle(4);
    @(negedge clk);
    check("idle_core_reset", 32'(core_reset), 32'd1);

    // Clean full image.
    start_dl();
    clean_body();
    check("dn_addr_hold", 32'(dn_addr), 32'(ROM_SIZE - 1));
    check("dn_data_hold", 32'(dn_data), 32'(dat(ROM_SIZE - 1)));
    $display("clean load done pulses=%0d", pulses);

    // user_reset in RUN: exactly HOLD cycles of core reset, rom_ok kept.
    next_cycle();
    user_reset = 1'b1;
    @(negedge clk);
    check("ureset_run_before", 32'(core_reset), 32'd0);
    next_cycle();
    user_reset = 1'b0;
    count_reset_high(n);
    check("ureset_hold_len", 32'(n), 32'(HOLD));
    check("ureset_rom_ok", 32'(rom_ok), 32'd1);
    $display("user reset hold=%0d", n);

    // RESET in the middle of LOAD with buffered bytes.
    start_dl();
    ce_en = 1'b0;
    for (int i = 0; i < 3; i++) write_byte(25'(i), dat(i), 1'b1);
    next_cycle();
    rst = 1'b1;
    idle(2);
    exp_q.delete();
    @(negedge clk);
    check("midrst_dn_addr", 32'(dn_addr), 32'd0);
    check("midrst_dn_data", 32'(dn_data), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_rom_ok", 32'(rom_ok), 32'd0);
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    next_cycle();
    rst = 1'b0;
    ce_en = 1'b1;
    write_byte(25'h5, 8'h55, 1'b0);
    idle(3);
    write_byte(25'hC000, 8'h66, 1'b0);
    idle(10);
    @(negedge clk);
    check("postrst_wr_ignored_err", 32'(err), 32'd0);
    check("postrst_busy", 32'(busy), 32'd1);
    end_dl();
    idle(2);
    start_dl();
    clean_body();
    $display("reset mid-load recovered");

    // Address range table.
    start_dl();
    ce_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      write_byte(vecs[i].addr, vecs[i].data, vecs[i].ok);
      idle(7);
      @(negedge clk);
      check("range_vec_err", 32'(err), 32'(vecs[i].exp_err));
      check("range_vec_popped", 32'(exp_q.size()), 32'd0);
      $display("vec %0d addr=%07h err=%03b", i, vecs[i].addr, err);
    end
    end_dl();
    idle(300);
    @(negedge clk);
    check("range_final_err", 32'(err), 32'b110);
    check("range_core_reset", 32'(core_reset), 32'd1);
    check("range_rom_ok", 32'(rom_ok), 32'd0);

    // Overflow burst with ce held low.
    start_dl();
    @(negedge clk);
    check("burst_err_cleared", 32'(err), 32'd0);
    ce_en = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(25'(16 + i), dat(i + 100), i < 4);
    next_cycle();
    @(negedge clk);
    check("burst_ovf", 32'(err), 32'b001);
    p0 = pulses;
    ce_en = 1'b1;
    idle(30);
    @(negedge clk);
    check("burst_pulses", 32'(pulses - p0), 32'd4);
    check("burst_drained", 32'(exp_q.size()), 32'd0);
    end_dl();
    idle(300);
    @(negedge clk);
    check("burst_final_err", 32'(err), 32'b101);
    check("burst_core_reset", 32'(core_reset), 32'd1);
    $display("burst done pulses=%0d", pulses - p0);

    // Short image ends in FAIL; user_reset ignored there.
    start_dl();
    feed(ROM_SIZE - 1);
    wait_q_empty();
    end_dl();
    idle(300);
    @(negedge clk);
    check("short_err", 32'(err), 32'b100);
    check("short_core_reset", 32'(core_reset), 32'd1);
    check("short_busy", 32'(busy), 32'd1);
    check("short_rom_ok", 32'(rom_ok), 32'd0);
    next_cycle();
    user_reset = 1'b1;
    next_cycle();
    user_reset = 1'b0;
    idle(300);
    @(negedge clk);
    check("short_ureset_core_reset", 32'(core_reset), 32'd1);
    check("short_ureset_err", 32'(err), 32'b100);

    // Restart during HOLD after a short image.
    start_dl();
    feed(ROM_SIZE - 1);
    wait_q_empty();
    end_dl();
    idle(100);
    @(negedge clk);
    check("hold_core_reset", 32'(core_reset), 32'd1);
    check("hold_err", 32'(err), 32'b100);
    start_dl();
    @(negedge clk);
    check("hold_restart_err", 32'(err), 32'd0);
    check("hold_restart_rom_ok", 32'(rom_ok), 32'd0);
    clean_body();
    $display("restart in hold recovered");

    // Restart during DRAIN with bytes still buffered: they must be dropped.
    start_dl();
    ce_en = 1'b0;
    for (int i = 0; i < 3; i++) write_byte(25'(i + 40), dat(i + 40), 1'b1);
    end_dl();
    next_cycle();
    next_cycle();
    ioctl_download = 1'b1;
    exp_q.delete();
    p0 = pulses;
    next_cycle();
    ce_en = 1'b1;
    idle(20);
    @(negedge clk);
    check("drain_restart_no_pulse", 32'(pulses - p0), 32'd0);
    check("drain_restart_err", 32'(err), 32'd0);
    clean_body();
    $display("restart in drain recovered");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
